data_memory_unit: RTL and testbench
===================================

Name: data_memory_unit

Overview:
- Data-memory stage directly downstream of the 64-bit ALU in the LEGv8 datapath.
- Consumes the ALU result as a byte address and performs doubleword loads and stores against an internal array.
- Access latency is parameterised, so the block raises a stall that holds the PC. The registered read_data feeds the write-back mux.

Parameters:
DEPTH_WORDS, 256, number of 64-bit doublewords in the array (power of two)
LATENCY, 2, cycles spent in BUSY per access (legal range 1..15)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
mem_read  input  1  load request from control unit, held for the whole instruction
mem_write  input  1  store request from control unit, held for the whole instruction
address  input  64  byte address from ALU result
write_data  input  64  store data (register file read port 2)
read_data  output  64  load result, registered
stall  output  1  hold PC / pipeline-free datapath while high
done  output  1  one-cycle pulse: access completed
err  output  1  combinational: current request rejected
err_sticky  output  1  set on any rejected request, cleared only by reset

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, counter=0, read_data=0, done=0, err_sticky=0.
  - Memory array is not cleared.
  - A reset mid-access discards the pending store or load; stall drops the cycle after reset is sampled.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Request valid = (mem_read XOR mem_write) AND address[2:0]==0 AND address < DEPTH_WORDS*8.
  - Valid request:
    - stall=1 combinationally in the same cycle.
    - Latch op, word index (address[log2(DEPTH_WORDS)+2:3]) and write_data.
    - Counter loads LATENCY-1; next state BUSY.
  - Invalid request (both mem_read and mem_write high, misaligned, or out of range):
    - err=1 and stall=0 in the same cycle; no memory access.
    - read_data unchanged; err_sticky set at the edge; stay IDLE.
  - No request: stall=0, err=0.
- BUSY:
  - stall=1.
  - Counter decrements each cycle.
  - At the edge where counter==0: a store commits the latched data to the array, or a load registers array[index] into read_data. Next state DONE.
  - Inputs are ignored in BUSY; latched values are used.
- DONE:
  - Lasts one cycle: done=1, stall=0, read_data valid.
  - mem_read/mem_write still belong to the completing instruction and are ignored (no re-trigger); next state IDLE.
- Timing: request presented in cycle t.
  - stall is high in cycles t..t+LATENCY.
  - done is high in cycle t+LATENCY+1.
  - Total occupancy is LATENCY+2 cycles, including DONE.
- read_data holds its value until the next completed load; stores and rejected requests do not alter it.
- Back-to-back accesses: a new request is accepted in the IDLE cycle immediately after DONE.
- err is only asserted in IDLE; it is 0 in BUSY and DONE.

Test Plan:
1. Reset, then store 0xDEADBEEF_CAFEF00D to address 0x10 (LATENCY=2).
   - stall high for 3 cycles, done pulse in cycle 4, read_data stays 0.
   - Then load 0x10: read_data=0xDEADBEEF_CAFEF00D in the done cycle.
2. Store 0x1 to 0x0, then load 0x7F8 (last word), then load 0x800.
   - Last-word load succeeds.
   - 0x800 gives err=1, stall=0, err_sticky=1, read_data unchanged.
3. Load from 0x0C (misaligned) and assert mem_read=mem_write=1 at 0x08.
   - Both give err=1 with no stall.
   - Memory at 0x08 is unchanged, verified by a subsequent load.
4. Assert rst_n=0 in the first BUSY cycle of a store of 0x55 to 0x20.
   - State returns to IDLE, stall=0, done never pulses, err_sticky=0.
   - A later load of 0x20 returns the previous contents.
5. Hold mem_read=1 through DONE, then issue a new load immediately.
   - Exactly one done per instruction; the second access is accepted in the IDLE cycle after DONE.
6. Sweep LATENCY=1 and LATENCY=15.
   - stall width is LATENCY+1 cycles; done arrives at t+LATENCY+1.

Source files
------------

// File: rtl/data_memory_unit_if.sv
// data_memory_unit_if: request/response bundle between the
// control/ALU side and the LEGv8 data-memory stage.
interface data_memory_unit_if;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] address;
    logic [63:0] write_data;
    logic [63:0] read_data;
    logic        stall;
    logic        done;
    logic        err;
    logic        err_sticky;

    modport master (
        output mem_read, mem_write, address, write_data,
        input  read_data, stall, done, err, err_sticky
    );

    modport slave (
        input  mem_read, mem_write, address, write_data,
        output read_data, stall, done, err, err_sticky
    );
endinterface

// File: rtl/data_memory_unit.sv
// data_memory_unit: doubleword load/store stage with a
// parameterised access latency, PC stall and error flags.
module data_memory_unit #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input logic               clk,
    input logic               rst_n,
    data_memory_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]    state;
    logic [3:0]    counter;
    logic          op_write;
    logic [AW-1:0] index;
    logic [63:0]   wdata_q;
    logic [63:0]   read_data_q;
    logic          sticky_q;
    logic [63:0]   mem [DEPTH_WORDS];

    logic req_any;
    logic req_ok;
    logic accept;
    logic commit;

    // Request qualification: one op, aligned, inside the array.
    always_comb begin
        req_any = bus.mem_read | bus.mem_write;
        req_ok  = (bus.mem_read ^ bus.mem_write)
               && (bus.address[2:0] == 3'b000)
               && (bus.address[63:AW+3] == '0);
        accept  = (state == IDLE) && req_ok;
        commit  = (state == BUSY) && (counter == 4'd0);
    end

    assign bus.stall      = accept || (state == BUSY);
    assign bus.done       = (state == DONE);
    assign bus.err        = (state == IDLE) && req_any && !req_ok;
    assign bus.read_data  = read_data_q;
    assign bus.err_sticky = sticky_q;

    // Access sequencer: IDLE -> BUSY (LATENCY cycles) -> DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= BUSY;
                        counter <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (counter == 4'd0) begin
                        state <= DONE;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Capture the accepted request; inputs are ignored afterwards.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_write <= bus.mem_write;
            index    <= bus.address[AW+2:3];
            wdata_q  <= bus.write_data;
        end
    end

    // Array write port; a reset at the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (rst_n && commit && op_write) begin
            mem[index] <= wdata_q;
        end
    end

    // Load result register and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read_data_q <= '0;
            sticky_q    <= 1'b0;
        end else begin
            if (commit && !op_write) begin
                read_data_q <= mem[index];
            end
            if (bus.err) begin
                sticky_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: scoreboard bench for the data-memory stage,
// main instance at LATENCY=2 plus LATENCY=1 and 15 instances.
module tb_data_memory_unit;
    localparam int LAT0 = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [63:0] addr = '0;
    logic [63:0] wdat = '0;

    int errors = 0;
    int checks = 0;

    logic [63:0] model [int];
    logic [63:0] exp_q [$];

    data_memory_unit_if if0 ();
    data_memory_unit_if if1 ();
    data_memory_unit_if if2 ();

    assign if0.mem_read = rd;
    assign if0.mem_write = wr;
    assign if0.address = addr;
    assign if0.write_data = wdat;
    assign if1.mem_read = rd;
    assign if1.mem_write = wr;
    assign if1.address = addr;
    assign if1.write_data = wdat;
    assign if2.mem_read = rd;
    assign if2.mem_write = wr;
    assign if2.address = addr;
    assign if2.write_data = wdat;

    data_memory_unit #(.DEPTH_WORDS(256), .LATENCY(LAT0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    data_memory_unit #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );
    data_memory_unit #(.DEPTH_WORDS(256), .LATENCY(15)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rd = 1'b0;
        wr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one request on dut0 and records what it did.
    task automatic run_access(
        input  logic        r,
        input  logic        w,
        input  logic [63:0] a,
        input  logic [63:0] d,
        output int          st_cnt,
        output int          done_at,
        output int          done_cnt,
        output logic        e0,
        output logic [63:0] rdd
    );
        st_cnt = 0;
        done_at = -1;
        done_cnt = 0;
        rdd = '0;
        @(negedge clk);
        rd = r;
        wr = w;
        addr = a;
        wdat = d;
        #1;
        e0 = if0.err;
        for (int c = 0; c < LAT0 + 5; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (done_at >= 0 || e0) begin
                    rd = 1'b0;
                    wr = 1'b0;
                end
                #1;
            end
            if (if0.stall) st_cnt++;
            if (if0.done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = c;
                    rdd = if0.read_data;
                end
            end
        end
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        #1;
        checks++;
        if (if0.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got=%b exp=0", if0.stall);
        end
        checks++;
        if (if0.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got=%b exp=0", if0.done);
        end
        checks++;
        if (if0.err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset_sticky got=%b exp=0", if0.err_sticky);
        end
        checks++;
        if (if0.read_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata got=%h exp=0", if0.read_data);
        end
    endtask

    task automatic test_store_load();
        int st, da, dc;
        logic e0;
        logic [63:0] rdd, expv;
        run_access(1'b0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D,
                   st, da, dc, e0, rdd);
        model[2] = 64'hDEADBEEF_CAFEF00D;
        checks++;
        if (e0 !== 1'b0 || st != 3) begin
            errors++;
            $display("FAIL store_stall err=%b stall_cycles=%0d exp 0/3", e0, st);
        end
        checks++;
        if (da != 3 || dc != 1) begin
            errors++;
            $display("FAIL store_done at=%0d count=%0d exp 3/1", da, dc);
        end
        checks++;
        if (rdd !== 64'h0) begin
            errors++;
            $display("FAIL store_rdata got=%h exp=0", rdd);
        end
        exp_q.push_back(model[2]);
        run_access(1'b1, 1'b0, 64'h10, 64'h0, st, da, dc, e0, rdd);
        expv = exp_q.pop_front();
        checks++;
        if (rdd !== expv || da != 3) begin
            errors++;
            $display("FAIL load_0x10 got=%h at=%0d exp=%h at 3", rdd, da, expv);
        end
    endtask

    task automatic test_boundary();
        int st, da, dc;
        logic e0;
        logic [63:0] rdd, expv, last;
        run_access(1'b0, 1'b1, 64'h0, 64'h1, st, da, dc, e0, rdd);
        model[0] = 64'h1;
        run_access(1'b0, 1'b1, 64'h7F8, 64'hA5A5_5A5A_0123_4567,
                   st, da, dc, e0, rdd);
        model[255] = 64'hA5A5_5A5A_0123_4567;
        exp_q.push_back(model[255]);
        run_access(1'b1, 1'b0, 64'h7F8, 64'h0, st, da, dc, e0, rdd);
        expv = exp_q.pop_front();
        checks++;
        if (rdd !== expv) begin
            errors++;
            $display("FAIL load_last got=%h exp=%h", rdd, expv);
        end
        last = expv;
        run_access(1'b1, 1'b0, 64'h800, 64'h0, st, da, dc, e0, rdd);
        checks++;
        if (e0 !== 1'b1 || st != 0 || dc != 0) begin
            errors++;
            $display("FAIL oor_err err=%b stall=%0d done=%0d exp 1/0/0", e0, st, dc);
        end
        checks++;
        if (if0.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL oor_sticky got=%b exp=1", if0.err_sticky);
        end
        checks++;
        if (if0.read_data !== last) begin
            errors++;
            $display("FAIL oor_rdata got=%h exp=%h", if0.read_data, last);
        end
    endtask

    task automatic test_misaligned();
        int st, da, dc;
        logic e0;
        logic [63:0] rdd, expv;
        run_access(1'b0, 1'b1, 64'h08, 64'h1234_5678_9ABC_DEF0,
                   st, da, dc, e0, rdd);
        model[1] = 64'h1234_5678_9ABC_DEF0;
        run_access(1'b1, 1'b0, 64'h0C, 64'h0, st, da, dc, e0, rdd);
        checks++;
        if (e0 !== 1'b1 || st != 0) begin
            errors++;
            $display("FAIL misaligned err=%b stall=%0d exp 1/0", e0, st);
        end
        run_access(1'b1, 1'b1, 64'h08, 64'hFFFF_FFFF_FFFF_FFFF,
                   st, da, dc, e0, rdd);
        checks++;
        if (e0 !== 1'b1 || st != 0 || dc != 0) begin
            errors++;
            $display("FAIL both_ops err=%b stall=%0d done=%0d exp 1/0/0", e0, st, dc);
        end
        exp_q.push_back(model[1]);
        run_access(1'b1, 1'b0, 64'h08, 64'h0, st, da, dc, e0, rdd);
        expv = exp_q.pop_front();
        checks++;
        if (rdd !== expv) begin
            errors++;
            $display("FAIL mem08_kept got=%h exp=%h", rdd, expv);
        end
    endtask

    task automatic test_reset_mid();
        int st, da, dc, ndone;
        logic e0;
        logic [63:0] rdd, expv;
        run_access(1'b0, 1'b1, 64'h20, 64'h7777_0000_1111_2222,
                   st, da, dc, e0, rdd);
        model[4] = 64'h7777_0000_1111_2222;
        @(negedge clk);
        wr = 1'b1;
        addr = 64'h20;
        wdat = 64'h55;
        @(negedge clk);
        rst_n = 1'b0;
        wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (if0.stall !== 1'b0 || if0.err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state stall=%b sticky=%b exp 0/0", if0.stall, if0.err_sticky);
        end
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            if (if0.done) ndone++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL rstmid_done got=%0d exp=0", ndone);
        end
        exp_q.push_back(model[4]);
        run_access(1'b1, 1'b0, 64'h20, 64'h0, st, da, dc, e0, rdd);
        expv = exp_q.pop_front();
        checks++;
        if (rdd !== expv) begin
            errors++;
            $display("FAIL rstmid_mem got=%h exp=%h", rdd, expv);
        end
    endtask

    task automatic test_back_to_back();
        int ndone, st_total;
        int dcyc [2];
        logic [63:0] rdv [2];
        logic st_after [2];
        logic switched;
        logic [63:0] expv;
        ndone = 0;
        st_total = 0;
        switched = 1'b0;
        dcyc[0] = -1;
        dcyc[1] = -1;
        st_after[0] = 1'b0;
        st_after[1] = 1'b0;
        @(negedge clk);
        rd = 1'b1;
        addr = 64'h10;
        exp_q.push_back(model[2]);
        #1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (ndone == 1 && !switched) begin
                    addr = 64'h0;
                    exp_q.push_back(model[0]);
                    switched = 1'b1;
                end
                if (ndone == 2) rd = 1'b0;
                #1;
            end
            if (if0.stall) st_total++;
            if (ndone == 1 && c == dcyc[0]) st_after[0] = if0.stall;
            if (ndone >= 1 && c == dcyc[0] + 1) st_after[1] = if0.stall;
            if (if0.done) begin
                if (ndone < 2) begin
                    dcyc[ndone] = c;
                    rdv[ndone] = if0.read_data;
                end
                ndone++;
                if (ndone == 1) st_after[0] = if0.stall;
            end
        end
        rd = 1'b0;
        checks++;
        if (ndone != 2 || dcyc[0] != 3 || dcyc[1] != 7) begin
            errors++;
            $display("FAIL b2b_done count=%0d at=%0d,%0d exp 2 at 3,7", ndone, dcyc[0], dcyc[1]);
        end
        checks++;
        if (st_after[0] !== 1'b0 || st_after[1] !== 1'b1 || st_total != 6) begin
            errors++;
            $display("FAIL b2b_stall done_cyc=%b next=%b total=%0d exp 0/1/6", st_after[0], st_after[1], st_total);
        end
        expv = exp_q.pop_front();
        checks++;
        if (rdv[0] !== expv) begin
            errors++;
            $display("FAIL b2b_rd0 got=%h exp=%h", rdv[0], expv);
        end
        expv = exp_q.pop_front();
        checks++;
        if (rdv[1] !== expv) begin
            errors++;
            $display("FAIL b2b_rd1 got=%h exp=%h", rdv[1], expv);
        end
    endtask

    task automatic test_latency_sweep();
        int st [3];
        int da [3];
        int lat [3];
        lat[0] = LAT0;
        lat[1] = 1;
        lat[2] = 15;
        for (int i = 0; i < 3; i++) begin
            st[i] = 0;
            da[i] = -1;
        end
        do_reset();
        @(negedge clk);
        rd = 1'b1;
        addr = 64'h18;
        #1;
        for (int c = 0; c < 22; c++) begin
            if (c > 0) begin
                @(negedge clk);
                rd = 1'b0;
                #1;
            end
            if (if0.stall) st[0]++;
            if (if1.stall) st[1]++;
            if (if2.stall) st[2]++;
            if (if0.done && da[0] < 0) da[0] = c;
            if (if1.done && da[1] < 0) da[1] = c;
            if (if2.done && da[2] < 0) da[2] = c;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (st[i] != lat[i] + 1) begin
                errors++;
                $display("FAIL sweep_stall lat=%0d got=%0d exp=%0d", lat[i], st[i], lat[i] + 1);
            end
            checks++;
            if (da[i] != lat[i] + 1) begin
                errors++;
                $display("FAIL sweep_done lat=%0d got=%0d exp=%0d", lat[i], da[i], lat[i] + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_boundary();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        test_latency_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
